// File: rtl/fdiv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fdiv_arbiter                                                         |
// | Round-robin sharing of one fdiv unit among NREQ order/accepted/done  |
// | requesters; one division outstanding, operands latched at grant.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fdiv_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_order,
  output logic [NREQ-1:0]    req_accepted,
  output logic [NREQ-1:0]    req_done,
  input  logic [NREQ*32-1:0] req_rs1,
  input  logic [NREQ*32-1:0] req_rs2,
  output logic [31:0]        rd,
  output logic               fu_order,
  input  logic               fu_accepted,
  input  logic               fu_done,
  output logic [31:0]        fu_rs1,
  output logic [31:0]        fu_rs2,
  input  logic [31:0]        fu_rd,
  output logic               busy,
  output logic [IDW-1:0]     owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);
  localparam logic [IDW:0]   c_nreq = (IDW + 1)'(NREQ);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [31:0]    r_rs1;
  logic [31:0]    r_rs2;
  logic           r_fu_order;
  logic           r_busy;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_win;
  logic              w_grant;
  logic              w_fin;
  logic [31:0]       w_sel1;
  logic [31:0]       w_sel2;

  // Rotating the doubled order vector by ptr puts the round-robin start at bit 0.
  assign w_dbl = {req_order, req_order};
  assign w_rot = NREQ'(w_dbl >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= c_nreq) ? IDW'(w_sum - c_nreq) : IDW'(w_sum);

  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IDW'(k)) begin
        w_sel1 = req_rs1[k*32 +: 32];
        w_sel2 = req_rs2[k*32 +: 32];
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && (|req_order);
  assign w_fin   = (r_state == S_WAIT) && fu_done;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req_accepted[g] = w_grant && (w_win == IDW'(g));
    assign req_done[g]     = w_fin && (r_owner == IDW'(g));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_fu_order <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_rs1      <= w_sel1;
            r_rs2      <= w_sel2;
            r_owner    <= w_win;
            r_fu_order <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fu_accepted) begin
            r_fu_order <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fu_done) begin
            r_ptr   <= (r_owner == c_last) ? '0 : r_owner + 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_fu_order <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign rd       = fu_rd;
  assign fu_order = r_fu_order;
  assign fu_rs1   = r_rs1;
  assign fu_rs2   = r_rs2;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fdiv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fdiv_arbiter                                                      |
// | Directed bench for fdiv_arbiter with a transaction-level model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fdiv_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;
  localparam int LAT  = 4;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_order;
  logic [NREQ-1:0]   req_accepted;
  logic [NREQ-1:0]   req_done;
  logic [NREQ*32-1:0] req_rs1;
  logic [NREQ*32-1:0] req_rs2;
  logic [31:0]       rd;
  logic              fu_order;
  logic              fu_accepted;
  logic              fu_done;
  logic [31:0]       fu_rs1;
  logic [31:0]       fu_rs2;
  logic [31:0]       fu_rd;
  logic              busy;
  logic [IDW-1:0]    owner;

  fdiv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .req_order(req_order), .req_accepted(req_accepted), .req_done(req_done),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .rd(rd),
    .fu_order(fu_order), .fu_accepted(fu_accepted), .fu_done(fu_done),
    .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_rd(fu_rd),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40400000, 32'h40000000}: return 32'h3FC00000;
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      {32'h3F800000, 32'h40800000}: return 32'h3E800000;
      default:                      return 32'hFFFFFFFF;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int k = 0; k < NREQ; k++) if (((v >> k) & 3'b001) != 3'b000) r = k;
    return r;
  endfunction

  // fdiv stand-in: optional accept stall, fixed latency, injectable stray done.
  int          stall_cfg;
  int          inj_req;
  int          inj_ack;
  int          st_cnt;
  int          fu_cnt;
  bit          fu_pending;
  logic [31:0] fu_q;

  initial begin : fu_model
    fu_accepted = 1'b0; fu_done = 1'b0; fu_rd = 32'hBAD00000;
    fu_pending = 1'b0; fu_cnt = 0; st_cnt = 0; inj_ack = 0; fu_q = '0;
    forever begin
      @(posedge clk); #2;
      fu_accepted = 1'b0; fu_done = 1'b0; fu_rd = 32'hBAD00000;
      if (!rstn) begin
        fu_pending = 1'b0; st_cnt = 0;
      end else if (inj_ack != inj_req) begin
        inj_ack = inj_req; fu_done = 1'b1; fu_rd = 32'h7FC00001;
      end else if (fu_pending) begin
        fu_cnt--;
        if (fu_cnt == 0) begin fu_done = 1'b1; fu_rd = fu_q; fu_pending = 1'b0; end
      end else if (fu_order) begin
        if (st_cnt < stall_cfg) st_cnt++;
        else begin
          st_cnt = 0; fu_accepted = 1'b1; fu_pending = 1'b1; fu_cnt = LAT;
          fu_q = quot(fu_rs1, fu_rs2);
        end
      end
    end
  end

  // Model state: at most one outstanding transaction.
  bit              m_has;
  bit              m_acked;
  int              m_ptr;
  int              m_own;
  logic [31:0]     m_a;
  logic [31:0]     m_b;
  logic [NREQ-1:0] acc_snap;
  logic [NREQ-1:0] done_snap;
  int              gq[$];
  int              dq[$];
  logic [31:0]     rq[$];

  initial begin
    m_has = 1'b0; m_acked = 1'b0; m_ptr = 0; m_own = 0; m_a = '0; m_b = '0;
    acc_snap = '0; done_snap = '0;
  end

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] e_acc;
    logic [NREQ-1:0] e_done;
    int w;
    int idx;
    e_acc = '0; e_done = '0; w = -1; idx = 0;
    if (!rstn) begin
      m_has = 1'b0; m_acked = 1'b0; m_ptr = 0; m_own = 0; m_a = '0; m_b = '0;
    end else begin
      if (!m_has) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && ((req_order >> idx) & 3'b001) != 3'b000) w = idx;
        end
      end
      if (w >= 0) e_acc = 3'b001 << w;
      if (m_has && m_acked && fu_done) e_done = 3'b001 << m_own;
    end
    check("req_accepted", 32'(req_accepted), 32'(e_acc));
    check("req_done", 32'(req_done), 32'(e_done));
    check("fu_order", 32'(fu_order), 32'(m_has && !m_acked));
    check("busy", 32'(busy), 32'(m_has));
    check("owner", 32'(owner), 32'(m_own));
    check("fu_rs1", fu_rs1, m_a);
    check("fu_rs2", fu_rs2, m_b);
    check("rd", rd, fu_rd);
    acc_snap = req_accepted;
    done_snap = req_done;
    if (req_accepted != '0) gq.push_back(onehot_idx(req_accepted));
    if (req_done != '0) begin dq.push_back(onehot_idx(req_done)); rq.push_back(rd); end
    if (rstn) begin
      if (e_done != '0) begin
        m_has = 1'b0; m_acked = 1'b0; m_ptr = (m_own + 1) % NREQ;
      end else if (m_has && !m_acked && fu_accepted) begin
        m_acked = 1'b1;
      end else if (w >= 0) begin
        m_has = 1'b1; m_acked = 1'b0; m_own = w;
        m_a = 32'(req_rs1 >> (32 * w));
        m_b = 32'(req_rs2 >> (32 * w));
      end
    end
  end

  logic [NREQ-1:0] reorder_mask;

  // Requesters drop order after their grant and optionally re-order after done.
  task automatic tick();
    @(posedge clk); #2;
    req_order = req_order & ~acc_snap;
    req_order = req_order | (done_snap & reorder_mask);
    reorder_mask = reorder_mask & ~done_snap;
  endtask

  task automatic wait_quiet(input int max);
    int n = 0;
    while ((busy || req_order != '0) && n < max) begin tick(); n++; end
    check("quiet_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int gb;
    int db;
    int n;
    rstn = 1'b0; req_order = '0; req_rs1 = '0; req_rs2 = '0;
    stall_cfg = 0; inj_req = 0; reorder_mask = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Single request from requester 1: 3.0 / 2.0
    gb = gq.size(); db = dq.size();
    req_rs1 = {32'h0, 32'h40400000, 32'h0};
    req_rs2 = {32'h0, 32'h40000000, 32'h0};
    req_order = 3'b010;
    wait_quiet(40);
    check("t1_ngrant", gq.size() - gb, 1);
    check("t1_grant", gq[gb], 1);
    check("t1_done_owner", dq[db], 1);
    check("t1_rd", rq[db], 32'h3FC00000);
    check("t1_busy", 32'(busy), 0);

    // Three simultaneous orders from ptr=0
    do_reset();
    gb = gq.size(); db = dq.size();
    req_rs1 = {32'h3F800000, 32'h41000000, 32'h40C00000};
    req_rs2 = {32'h40800000, 32'h40000000, 32'h40000000};
    req_order = 3'b111;
    wait_quiet(80);
    check("t2_ngrant", gq.size() - gb, 3);
    check("t2_g0", gq[gb], 0);
    check("t2_g1", gq[gb+1], 1);
    check("t2_g2", gq[gb+2], 2);
    check("t2_d0", dq[db], 0);
    check("t2_d1", dq[db+1], 1);
    check("t2_d2", dq[db+2], 2);
    check("t2_rd0", rq[db], 32'h40400000);
    check("t2_rd1", rq[db+1], 32'h40800000);
    check("t2_rd2", rq[db+2], 32'h3E800000);

    // Fairness: 0 and 2 each re-order once after their done
    do_reset();
    gb = gq.size(); db = dq.size();
    req_rs1 = {32'h41000000, 32'h0, 32'h40C00000};
    req_rs2 = {32'h40000000, 32'h0, 32'h40000000};
    reorder_mask = 3'b101;
    req_order = 3'b101;
    wait_quiet(120);
    check("t3_ngrant", gq.size() - gb, 4);
    check("t3_g0", gq[gb], 0);
    check("t3_g1", gq[gb+1], 2);
    check("t3_g2", gq[gb+2], 0);
    check("t3_g3", gq[gb+3], 2);
    check("t3_rd1", rq[db+1], 32'h40800000);
    check("t3_rd2", rq[db+2], 32'h40400000);

    // Stalled FU with owner operands changing and a stray done in ISSUE
    do_reset();
    db = dq.size();
    stall_cfg = 5;
    req_rs1 = {32'h0, 32'h0, 32'h3F800000};
    req_rs2 = {32'h0, 32'h0, 32'h40800000};
    req_order = 3'b001;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_fu_order", 32'(fu_order), 1);
      check("t4_fu_rs1", fu_rs1, 32'h3F800000);
      check("t4_fu_rs2", fu_rs2, 32'h40800000);
      if (i == 1) begin req_rs1[31:0] = 32'h12345678; inj_req++; end
      tick();
    end
    stall_cfg = 0;
    wait_quiet(40);
    check("t4_ndone", dq.size() - db, 1);
    check("t4_rd", rq[db], 32'h3E800000);

    // Async reset while in WAIT
    do_reset();
    req_rs1 = {32'h3F800000, 32'h41000000, 32'h40C00000};
    req_rs2 = {32'h40800000, 32'h40000000, 32'h40000000};
    req_order = 3'b001;
    wait_quiet(40);
    req_order = 3'b010;
    n = 0;
    do begin tick(); n++; end while (!(busy && !fu_order) && n < 20);
    check("t5_reach_wait", 32'(n < 20), 1);
    #1 rstn = 1'b0;
    #1;
    check("t5_busy_async", 32'(busy), 0);
    check("t5_fu_order_async", 32'(fu_order), 0);
    check("t5_done_async", 32'(req_done), 0);
    check("t5_owner_async", 32'(owner), 0);
    tick(); tick();
    rstn = 1'b1;
    db = dq.size(); gb = gq.size();
    inj_req++;
    repeat (LAT + 2) tick();
    check("t5_no_late_done", dq.size() - db, 0);
    req_order = 3'b101;
    wait_quiet(80);
    check("t5_ngrant", gq.size() - gb, 2);
    check("t5_g0", gq[gb], 0);
    check("t5_g1", gq[gb+1], 2);

    // Stray done in IDLE; ptr has wrapped 2 -> 0
    db = dq.size(); gb = gq.size();
    inj_req++;
    repeat (3) tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_owner", 32'(owner), 2);
    check("t6_ndone", dq.size() - db, 0);
    req_order = 3'b011;
    wait_quiet(40);
    check("t6_grant", gq[gb], 0);
    check("t6_grant2", gq[gb+1], 1);
    check("t6_rd", rq[db+1], 32'h40800000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fdiv_arbiter.md
Name: fdiv_arbiter

Overview:
- Shares one fdiv instance among NREQ requesters, e.g. the three reciprocal-step divisions of a square-root unit plus a scalar fdiv issue port.
- Requester side and FPU side both use the FPU order/accepted/done handshake.
- At most one division is outstanding. Grants are round-robin; operands are latched at grant.
- Sits between requester pipelines and a single fdiv.

Parameters:
NREQ, 3, number of requesters (2..8)
IDW, 2, owner-index width, ceil(log2(NREQ)), minimum 1

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; one clock; reset is asynchronous and active-low
req_order  in  NREQ  per-requester order, held until its accepted is seen
req_accepted  out  NREQ  one-hot grant pulse, combinational
req_done  out  NREQ  one-hot completion pulse to the owner
req_rs1  in  NREQ*32  dividends, requester i at bits [32i+31:32i]
req_rs2  in  NREQ*32  divisors, same packing
rd  out  32  quotient, broadcast; valid in the cycle req_done[owner]=1
fu_order  out  1  order to fdiv
fu_accepted  in  1  fdiv accepted
fu_done  in  1  fdiv done
fu_rs1  out  32  latched dividend
fu_rs2  out  32  latched divisor
fu_rd  in  32  fdiv result
busy  out  1  state != IDLE
owner  out  IDW  index of current/last granted requester

Behaviour:
- Reset (async, rstn=0): state=IDLE, ptr=0, owner=0, fu_rs1=fu_rs2=0. fu_order=0, busy=0, req_accepted=0, req_done=0 immediately, with no clock.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_order bit is set, winner w = first set bit scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_accepted[w]=1 combinationally in that cycle; all other bits 0.
  - Clock edge: fu_rs1/fu_rs2 <= req_rs1/req_rs2 slice w, owner<=w, go to ISSUE.
  - No order: stay in IDLE, all outputs idle.
- ISSUE:
  - fu_order=1.
  - fu_accepted=1: go to WAIT; fu_order is 0 from the next cycle.
  - fu_accepted=0: hold fu_order and operands stable.
- WAIT:
  - fu_order=0.
  - On fu_done=1: req_done[owner]=1 combinationally, rd=fu_rd in the same cycle, ptr<=(owner+1) mod NREQ, go to IDLE.
- rd = fu_rd at all times. It is meaningful only with req_done.
- req_accepted is only asserted in IDLE. A requester ordering while busy waits; its order stays high.
- Minimum turnaround: done cycle (WAIT), then IDLE grant cycle, then ISSUE. A new grant cannot occur in the done cycle.
- Fairness: a requester holding order is granted within NREQ-1 other completions.
- Simultaneous orders are resolved only by ptr; lower index has no fixed priority.
- fu_done seen in IDLE or ISSUE is a protocol error. It is ignored: no req_done, no state change.
- A requester dropping order in the grant cycle is not supported; a grant is final once req_accepted pulses.
- Reset mid-operation abandons the outstanding divide with no req_done. fdiv shares rstn and is reset too.
- The ptr wrap uses explicit compare to NREQ-1, not natural overflow, so non-power-of-two NREQ works.

Test Plan:
- Single request, NREQ=3: req_order=3'b010, rs1=0x40400000 (3.0), rs2=0x40000000 (2.0), fdiv model 4-cycle latency -> req_accepted=010 for 1 cycle; fu_order one cycle later; req_done=010 with rd=0x3FC00000; busy returns to 0.
- All three order in the same cycle from reset (ptr=0) -> grants in order 0, 1, 2. Each req_done matches its owner and its own operands: 6/2=3, 8/2=4, 1/4=0.25 -> 0x40400000, 0x40800000, 0x3E800000.
- Fairness: requester 0 re-orders immediately after each done while 2 holds order -> sequence 0, 2, 0, 2 (requester 1 idle); 0 is never granted twice in a row while 2 waits.
- Stalled FU: fu_accepted held 0 for 5 cycles -> fu_order stays 1, fu_rs1/fu_rs2 are stable, and changing req_rs1 of the owner has no effect.
- Async reset in WAIT: rstn low mid-cycle -> busy, fu_order, req_done go 0 without a clock edge; no late req_done after release even if a stale fu_done pulses; next grant starts from ptr=0.
- Spurious fu_done in IDLE -> req_done=0, state unchanged.
